// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage. Owns the PC, drives the instruction
// memory, captures the returned word into the IF/ID register and handles
// stall, redirect and HALT detection.
module fetch_stage #(
   parameter logic [15:0] RESET_PC    = 16'h0000,
   parameter logic [15:0] NOP_INST    = 16'h0800,
   parameter logic [4:0]  HALT_OPCODE = 5'b00000
) (
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] imem_addr,
   output logic        imem_en,
   input  logic [15:0] imem_inst,
   input  logic        stall,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   output logic [15:0] if_id_inst,
   output logic [15:0] if_id_pc_plus2,
   output logic        if_id_valid,
   output logic        halted,
   output logic [15:0] fetch_count
);

   logic [15:0] pc_q, pc_d;
   logic [15:0] inst_q, inst_d;
   logic [15:0] pc_plus2_q, pc_plus2_d;
   logic        valid_q, valid_d;
   logic        halted_q, halted_d;
   logic [15:0] fetch_count_q, fetch_count_d;

   logic [15:0] pc_next_seq;
   logic        is_halt;

   assign pc_next_seq = pc_q + 16'd2;
   assign is_halt     = (imem_inst[15:11] == HALT_OPCODE);

   // Next-state selection in priority order: redirect, halted, stall, normal fetch.
   always_comb begin
      pc_d          = pc_q;
      inst_d        = inst_q;
      pc_plus2_d    = pc_plus2_q;
      valid_d       = valid_q;
      halted_d      = halted_q;
      fetch_count_d = fetch_count_q;
      if (redirect) begin
         pc_d       = redirect_pc;
         inst_d     = NOP_INST;
         pc_plus2_d = 16'h0000;
         valid_d    = 1'b0;
         halted_d   = 1'b0;
      end else if (halted_q) begin
         inst_d     = NOP_INST;
         pc_plus2_d = 16'h0000;
         valid_d    = 1'b0;
      end else if (!stall) begin
         inst_d     = imem_inst;
         pc_plus2_d = pc_next_seq;
         valid_d    = 1'b1;
         if (fetch_count_q != 16'hFFFF) begin
            fetch_count_d = fetch_count_q + 16'd1;
         end
         if (is_halt) begin
            halted_d = 1'b1;
         end else begin
            pc_d = pc_next_seq;
         end
      end
   end

   // State register with synchronous reset taking precedence over everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q          <= RESET_PC;
         inst_q        <= NOP_INST;
         pc_plus2_q    <= 16'h0000;
         valid_q       <= 1'b0;
         halted_q      <= 1'b0;
         fetch_count_q <= 16'h0000;
      end else begin
         pc_q          <= pc_d;
         inst_q        <= inst_d;
         pc_plus2_q    <= pc_plus2_d;
         valid_q       <= valid_d;
         halted_q      <= halted_d;
         fetch_count_q <= fetch_count_d;
      end
   end

   assign imem_addr      = pc_q;
   assign imem_en        = ~halted_q;
   assign if_id_inst     = inst_q;
   assign if_id_pc_plus2 = pc_plus2_q;
   assign if_id_valid    = valid_q;
   assign halted         = halted_q;
   assign fetch_count    = fetch_count_q;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined processor. It owns the program counter, drives the address and enable of the instruction memory, and takes the returned instruction combinationally in the same cycle. It latches that instruction and PC+2 into the IF/ID pipeline register that feeds decode. It also handles stall, redirect (branch/jump) and HALT detection.

## Interface
- `RESET_PC`, default 16'h0000: PC value after reset.
- `NOP_INST`, default 16'h0800: instruction injected into IF/ID on flush or bubble.
- `HALT_OPCODE`, default 5'b00000: value of inst[15:11] that identifies HALT.
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_addr`  out  16  instruction-memory address; always equals the PC register.
- `imem_en`  out  1  instruction-memory enable; equals ~halted.
- `imem_inst`  in  16  instruction read at `imem_addr`, valid in the same cycle (combinational read).
- `stall`  in  1  hazard stall from decode: hold PC and IF/ID.
- `redirect`  in  1  taken branch/jump resolved downstream.
- `redirect_pc`  in  16  target PC, valid when `redirect`=1.
- `if_id_inst`  out  16  registered instruction to decode.
- `if_id_pc_plus2`  out  16  registered PC+2 of that instruction.
- `if_id_valid`  out  1  IF/ID holds a real fetched instruction.
- `halted`  out  1  HALT has been fetched; fetch is frozen.
- `fetch_count`  out  16  number of instructions delivered to IF/ID, saturating.

## Operation
- State: PC (16), IF/ID {inst, pc_plus2, valid}, halted (1), fetch_count (16).
- The control sources are evaluated in a fixed priority each cycle: rst > redirect > halted > stall > normal.
- **rst:**
  - PC←RESET_PC; IF/ID←{NOP_INST, 16'h0000, 0}; halted←0; fetch_count←0.
- **redirect=1:** applies whether or not the stage is stalled or halted.
  - PC←redirect_pc; IF/ID←{NOP_INST, 0, 0} (flush); halted←0.
  - `redirect_pc` is used unaltered; bit 0 is not forced to zero.
- **halted=1, no redirect:**
  - PC holds; IF/ID←{NOP_INST, 0, 0}.
  - `imem_en`=0.
- **stall=1, not halted, no redirect:**
  - PC and IF/ID hold their values; no fetch is accepted.
- **normal:**
  - PC←PC+2, modulo 2^16, so 16'hFFFE wraps to 16'h0000.
  - IF/ID←{imem_inst, PC+2, 1}.
  - fetch_count←fetch_count+1, saturating at 16'hFFFF.
  - If imem_inst[15:11]==HALT_OPCODE: halted←1 and PC holds instead of incrementing.
  - The HALT instruction itself is delivered to IF/ID with valid=1 so it retires downstream.
- HALT detection happens only on an accepted fetch. A HALT word present at `imem_inst` during stall or redirect has no effect.
- The IF/ID outputs are driven directly from registers; no combinational path runs from inputs to the IF/ID outputs.

## Timing
- Reset values: imem_addr=RESET_PC, imem_en=1, if_id_inst=NOP_INST, if_id_pc_plus2=0, if_id_valid=0, halted=0, fetch_count=0.
- Fetch latency is one cycle. The instruction at address A appears on if_id_inst on the edge after imem_addr=A is presented with stall=0.
- Redirect is asserted in cycle N:
  - imem_addr=redirect_pc in cycle N+1.
  - if_id_valid=0 in N+1.
  - The target instruction appears in IF/ID in N+2.
- HALT is fetched at address A in cycle N:
  - In N+1: if_id_inst=HALT, halted=1, imem_en=0, imem_addr=A.
  - From N+2 on: if_id_valid=0.
- Stall in cycle N: all registered outputs in N+1 equal their values in N.
- rst asserted mid-operation overrides everything on that edge, including a simultaneous redirect or HALT.

## Test plan
- **Reset, then sequential fetch.** Stimulus: memory holds 16'h4000 at address 0 and 16'h4100 at address 2. Required: after rst, imem_addr steps 0, 2, 4; IF/ID shows {4000, 0002, 1} then {4100, 0004, 1}; fetch_count=2.
- **Stall.** Stimulus: stall=1 for 3 cycles at PC=6. Required: imem_addr stays 6 and IF/ID stays unchanged for 3 cycles; fetch resumes from 6; fetch_count does not advance during the stall.
- **Redirect.** Stimulus: redirect=1 with redirect_pc=16'h0100 at PC=8, once with stall=0 and once with stall=1. Required: imem_addr=0100 next cycle and if_id_valid=0 in both cases; the instruction at 0100 arrives in IF/ID with pc_plus2=0102.
- **Halt.** Stimulus: 16'h0000 at address 0x0A. Required: IF/ID={0000, 000C, 1}; halted=1; imem_en=0; imem_addr stays 0A; if_id_valid=0 afterwards. A later redirect to 0x20 clears halted and fetch resumes at 0x20.
- **Halt word during stall.** Stimulus: 16'h0000 present at imem_inst while stall=1. Required: halted stays 0. When stall drops, HALT is taken as in the halt scenario.
- **Wrap-around and reset.** Stimulus: redirect to 16'hFFFE, then a normal fetch. Required: next imem_addr=0000 and if_id_pc_plus2=0000. Then rst asserted together with redirect: all outputs return to their reset values.
